// File: rtl/spin_quad_tx.sv
// spin_quad_tx: transmit side of the spinner delta interface.
// Accepts 9-bit spin packets {toggle, signed delta}. Each change of the toggle bit is a new
// packet. The deltas are summed into a saturating pending-step accumulator, which is then
// replayed as a rate-limited 2-bit quadrature (A/B) stream, one step every STEP_DIV ce pulses.
//
// Ports:
//   clk     - system clock, all state on posedge
//   reset   - asynchronous active-high reset
//   ce      - step-rate clock enable for the step divider
//   spin_in - [8] packet toggle, [7:0] signed delta
//   clear   - synchronous drop of pending steps (phase kept)
//   quad_a  - quadrature A (registered)
//   quad_b  - quadrature B (registered)
//   dir     - direction of last emitted step, 1 = phase increment
//   busy    - pending steps remain (registered)
module spin_quad_tx #(
    parameter int unsigned STEP_DIV   = 64,
    parameter int unsigned ACC_W      = 12,
    parameter bit          INVERT_DIR = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [8:0] spin_in,
    input  logic       clear,
    output logic       quad_a,
    output logic       quad_b,
    output logic       dir,
    output logic       busy
);

    localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(STEP_DIV - 1);
    localparam logic signed [ACC_W:0] SAT_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    logic                    tog_r;
    logic                    armed;
    logic signed [ACC_W-1:0] pending;
    logic [DIV_W-1:0]        div_cnt;
    logic [1:0]              phase;

    logic                    packet;
    logic                    step;
    logic                    step_up;
    logic                    phase_fwd;
    logic signed [ACC_W:0]   delta;
    logic signed [ACC_W:0]   add_term;
    logic signed [ACC_W:0]   sub_term;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W-1:0] pending_next;
    logic [1:0]              phase_next;

    always_comb begin
        // clear wins over a same-cycle packet and suppresses any step
        packet  = armed & (tog_r ^ spin_in[8]) & ~clear;
        step    = (pending != '0) & ce & (div_cnt == DIV_MAX) & ~clear;
        step_up = ~pending[ACC_W-1];
        delta   = {{(ACC_W-7){spin_in[7]}}, spin_in[7:0]};

        add_term = packet ? delta : '0;
        sub_term = '0;
        if (step) begin
            sub_term = step_up ? (ACC_W+1)'(1) : {(ACC_W+1){1'b1}};
        end

        // One extra bit is enough: |pending + delta - s| < 2^ACC_W for ACC_W >= 9
        sum = {pending[ACC_W-1], pending} + add_term - sub_term;

        if (clear) begin
            pending_next = '0;
        end else if (sum > SAT_MAX) begin
            pending_next = SAT_MAX[ACC_W-1:0];
        end else if (sum < SAT_MIN) begin
            pending_next = SAT_MIN[ACC_W-1:0];
        end else begin
            pending_next = sum[ACC_W-1:0];
        end

        phase_fwd  = step_up ^ INVERT_DIR;
        phase_next = phase;
        if (step) begin
            phase_next = phase_fwd ? phase + 2'd1 : phase - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tog_r   <= 1'b0;
            armed   <= 1'b0;
            pending <= '0;
            div_cnt <= '0;
            phase   <= 2'd0;
            quad_a  <= 1'b0;
            quad_b  <= 1'b0;
            dir     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            tog_r   <= spin_in[8];
            armed   <= 1'b1;
            pending <= pending_next;
            phase   <= phase_next;

            if (clear || pending == '0) begin
                div_cnt <= '0;
            end else if (ce) begin
                if (div_cnt == DIV_MAX) begin
                    div_cnt <= '0;
                end else if (pending_next != '0) begin
                    // A cancelling packet holds the divider; it clears next cycle
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            if (step) begin
                dir <= phase_fwd;
            end

            // Gray mapping 0->00, 1->10, 2->11, 3->01
            quad_a <= phase_next[0] ^ phase_next[1];
            quad_b <= phase_next[1];
            busy   <= (pending_next != '0);
        end
    end

endmodule

// File: tb/tb_spin_quad_tx.sv
module tb_spin_quad_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b1;
    logic       clear = 1'b0;
    logic [8:0] spin_in = 9'h000;
    logic [8:0] spin3 = 9'h000;
    logic       quad_a, quad_b, dir, busy;
    logic       quad_a3, quad_b3, dir3, busy3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spin_quad_tx #(.STEP_DIV(4), .ACC_W(12), .INVERT_DIR(1'b0)) dut (
        .clk(clk), .reset(reset), .ce(ce), .spin_in(spin_in), .clear(clear),
        .quad_a(quad_a), .quad_b(quad_b), .dir(dir), .busy(busy)
    );

    spin_quad_tx #(.STEP_DIV(1000), .ACC_W(9), .INVERT_DIR(1'b0)) dut3 (
        .clk(clk), .reset(reset), .ce(ce), .spin_in(spin3), .clear(clear),
        .quad_a(quad_a3), .quad_b(quad_b3), .dir(dir3), .busy(busy3)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expect the next A/B step exactly 4 clocks from now, with A/B stable before it
    task automatic expect_step(input string tag, input logic [1:0] prev_ab,
                               input logic [1:0] new_ab, input logic exp_dir);
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, "_hold"}, {30'd0, quad_a, quad_b}, {30'd0, prev_ab});
        end
        tick();
        check({tag, "_ab"}, {30'd0, quad_a, quad_b}, {30'd0, new_ab});
        check({tag, "_dir"}, {31'd0, dir}, {31'd0, exp_dir});
    endtask

    initial begin
        tick(2);
        check("rst_ab", {30'd0, quad_a, quad_b}, 32'd0);
        check("rst_dir", {31'd0, dir}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Test 3: saturation on a 9-bit accumulator
        spin3 = 9'h17F; tick(); check("sat_p1", {23'd0, dut3.pending}, 32'h07F);
        spin3 = 9'h07F; tick(); check("sat_p2", {23'd0, dut3.pending}, 32'h0FE);
        spin3 = 9'h17F; tick(); check("sat_p3", {23'd0, dut3.pending}, 32'h0FF);
        check("sat_busy", {31'd0, busy3}, 32'd1);
        spin3 = 9'h080; tick(); check("sat_n1", {23'd0, dut3.pending}, 32'h07F);
        spin3 = 9'h180; tick(); check("sat_n2", {23'd0, dut3.pending}, 32'h1FF);
        spin3 = 9'h080; tick(); check("sat_n3", {23'd0, dut3.pending}, 32'h17F);
        spin3 = 9'h180; tick(); check("sat_n4", {23'd0, dut3.pending}, 32'h100);
        spin3 = 9'h080; tick(); check("sat_n5", {23'd0, dut3.pending}, 32'h100);

        // Test 1: +5 walks forward
        reset = 1'b1; tick(); reset = 1'b0; tick(2);
        spin_in = 9'h105; tick();
        check("t1_busy0", {31'd0, busy}, 32'd1);
        check("t1_ab0", {30'd0, quad_a, quad_b}, 32'd0);
        expect_step("t1_s1", 2'b00, 2'b10, 1'b1);
        expect_step("t1_s2", 2'b10, 2'b11, 1'b1);
        expect_step("t1_s3", 2'b11, 2'b01, 1'b1);
        expect_step("t1_s4", 2'b01, 2'b00, 1'b1);
        check("t1_busy4", {31'd0, busy}, 32'd1);
        expect_step("t1_s5", 2'b00, 2'b10, 1'b1);
        check("t1_busy5", {31'd0, busy}, 32'd0);

        // Test 2: -3 walks backward
        spin_in = 9'h0FD; tick();
        check("t2_busy0", {31'd0, busy}, 32'd1);
        expect_step("t2_s1", 2'b10, 2'b00, 1'b0);
        expect_step("t2_s2", 2'b00, 2'b01, 1'b0);
        expect_step("t2_s3", 2'b01, 2'b11, 1'b0);
        check("t2_busy3", {31'd0, busy}, 32'd0);

        // Test 4: cancelling packet before the first step
        spin_in = 9'h102; tick();
        check("t4_busy", {31'd0, busy}, 32'd1);
        tick();
        spin_in = 9'h0FE; tick();
        check("t4_cancel_busy", {31'd0, busy}, 32'd0);
        tick(8);
        check("t4_ab", {30'd0, quad_a, quad_b}, 32'h3);
        check("t4_busy_late", {31'd0, busy}, 32'd0);

        // Test 5: clear after two steps of +10
        reset = 1'b1; tick(); reset = 1'b0; tick();
        spin_in = 9'h10A; tick();
        expect_step("t5_s1", 2'b00, 2'b10, 1'b1);
        expect_step("t5_s2", 2'b10, 2'b11, 1'b1);
        clear = 1'b1; tick(); clear = 1'b0;
        check("t5_busy_clr", {31'd0, busy}, 32'd0);
        tick(20);
        check("t5_ab", {30'd0, quad_a, quad_b}, 32'h3);
        check("t5_busy", {31'd0, busy}, 32'd0);

        // Test 6: toggle high at reset release, data change without toggle, async reset
        spin_in = 9'h1FF; reset = 1'b1; tick(); reset = 1'b0;
        tick(10);
        check("t6_arm_busy", {31'd0, busy}, 32'd0);
        check("t6_arm_ab", {30'd0, quad_a, quad_b}, 32'd0);
        spin_in = 9'h155; tick(10);
        check("t6_notog_busy", {31'd0, busy}, 32'd0);
        check("t6_notog_ab", {30'd0, quad_a, quad_b}, 32'd0);
        spin_in = 9'h020; tick();
        check("t6_burst_busy", {31'd0, busy}, 32'd1);
        expect_step("t6_s1", 2'b00, 2'b10, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_ab", {30'd0, quad_a, quad_b}, 32'd0);
        check("t6_async_busy", {31'd0, busy}, 32'd0);
        check("t6_async_dir", {31'd0, dir}, 32'd0);
        tick();
        reset = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
